// File: rtl/key_event_if.sv
// Avalon-MM register bus and interrupt line between the CPU and the key controller.
// Latency: none, plain wires.
// Backpressure: none; the slave accepts every access in the cycle it is presented.
interface key_event_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/key_event_controller.sv
// Debounced push-button controller: sync, debounce, press capture, irq mask, press counter.
// Latency: raw key edge to DATA/EDGE change 2+DEB_CYCLES clk; readdata 1 clk after a read.
// Backpressure: none; every access completes in one cycle, irq is a registered level.
module key_event_controller #(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  key_event_if.slave       bus
);

  localparam int PW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [15:0]      count_q, count_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] press;
  logic [PW-1:0]    press_cnt;
  logic [16:0]      count_sum;
  logic             wr, rd;
  logic             unused_wdata;

  // Keys are active-low; after the synchroniser a 1 means "held down".
  assign pressed = ~sync2_q;
  assign wr      = bus.chipselect & ~bus.write_n;
  assign rd      = bus.chipselect &  bus.write_n;

  // Only the per-key bits of writedata carry meaning; COUNT clears on any write.
  assign unused_wdata = ^bus.writedata[31:WIDTH];

  // Per-key debounce: a level is accepted after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
          stable_d[i] = pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Press events are the 0->1 transitions of the accepted level; releases are silent.
  always_comb begin
    press     = stable_d & ~stable_q;
    press_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      press_cnt = press_cnt + PW'(press[i]);
    end
  end

  // Register updates: sticky EDGE (set beats clear), MASK, saturating COUNT (press beats clear).
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr && bus.address == 2'd1) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr && bus.address == 2'd2) begin
      edge_d = edge_q & ~bus.writedata[WIDTH-1:0];
    end
    edge_d = edge_d | press;

    count_sum = {1'b0, count_q} + 17'(press_cnt);
    if (wr && bus.address == 2'd3) begin
      count_d = 16'(press_cnt);
    end else if (count_sum[16]) begin
      count_d = 16'hFFFF;
    end else begin
      count_d = count_sum[15:0];
    end
  end

  // Read mux samples pre-edge register values; readdata holds when not reading.
  always_comb begin
    readdata_d = readdata_q;
    if (rd) begin
      case (bus.address)
        2'd0:    readdata_d = 32'(stable_q);
        2'd1:    readdata_d = 32'(mask_q);
        2'd2:    readdata_d = 32'(edge_q);
        default: readdata_d = 32'(count_q);
      endcase
    end
    irq_d = |(edge_q & mask_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      cnt_q      <= '{default: '0};
      edge_q     <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule
